// File: rtl/ebpc_pkg.sv
// ebpc_pkg
// Shared definitions for the sequential bit-plane coder datapath.
//   DATA_W      : input word width
//   BLOCK_SIZE  : words grouped into one block (2 <= BLOCK_SIZE <= DATA_W)
//   CNT_W       : width of the in-block word counter
//   delta_t     : one two's-complement delta, DATA_W+1 bits
//   plane_t     : one bit-plane, one bit per delta (BLOCK_SIZE-1 bits)
//   dbp_block_t : base word plus DATA_W+1 DBX planes, as consumed by the coder
package ebpc_pkg;

    localparam int DATA_W     = 8;
    localparam int BLOCK_SIZE = 8;
    localparam int CNT_W      = $clog2(BLOCK_SIZE);

    typedef logic [DATA_W:0]       delta_t;
    typedef logic [BLOCK_SIZE-2:0] plane_t;

    typedef struct packed {
        logic [DATA_W-1:0]  base;
        plane_t [DATA_W:0]  dbp;
    } dbp_block_t;

    // Difference of two unsigned words, modulo 2^(DATA_W+1).
    function automatic delta_t delta_fn(input logic [DATA_W-1:0] cur,
                                        input logic [DATA_W-1:0] prev);
        return {1'b0, cur} - {1'b0, prev};
    endfunction

endpackage

// File: rtl/dbx_transform.sv
// dbx_transform
// Purely combinational: transposes a block of deltas into bit-planes and
// XORs each plane with the plane above it.
//   delta : BLOCK_SIZE-1 deltas, index i is the i-th delta of the block
//   dbx   : DATA_W+1 DBX planes; plane bit i corresponds to delta i
module dbx_transform
    import ebpc_pkg::*;
(
    input  delta_t [BLOCK_SIZE-2:0] delta,
    output plane_t [DATA_W:0]       dbx
);

    plane_t [DATA_W:0] plane_s;

    // Transpose: plane j gathers bit j of every delta, LSB = first delta.
    always_comb begin
        plane_s = '0;
        for (int j = 0; j <= DATA_W; j++) begin
            for (int i = 0; i < BLOCK_SIZE - 1; i++) begin
                plane_s[j][i] = delta[i][j];
            end
        end
    end

    // Top plane passes through; every lower plane is XORed with its upper neighbour.
    always_comb begin
        dbx = '0;
        dbx[DATA_W] = plane_s[DATA_W];
        for (int j = 0; j < DATA_W; j++) begin
            dbx[j] = plane_s[j] ^ plane_s[j+1];
        end
    end

endmodule

// File: rtl/dbx_block_former.sv
// dbx_block_former
// Groups a word stream into blocks of BLOCK_SIZE, forms consecutive deltas,
// and emits base + DBX planes per block. Partial blocks are zero-padded on
// flush, and the flush is then forwarded to the downstream coder.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   data_i/vld_i/rdy_o            : input word stream
//   flush_i                       : single-cycle flush request
//   dbp_block_o/vld_o/rdy_i       : output block stream
//   flush_o/flush_done_i          : flush forwarding handshake
//   idle_o                        : nothing buffered, no flush outstanding
module dbx_block_former
    import ebpc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    output logic              rdy_o,
    input  logic              flush_i,
    output dbp_block_t        dbp_block_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              flush_o,
    input  logic              flush_done_i,
    output logic              idle_o
);

    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_PAD        = 2'd1,
        ST_FLUSH_WAIT = 2'd2,
        ST_FLUSH_HOLD = 2'd3
    } state_e;

    state_e                   state_r, state_nxt_s;
    logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0]        base_r, prev_r, word_s;
    delta_t [BLOCK_SIZE-2:0]  delta_r, tx_delta_s;
    delta_t                   delta_new_s;
    plane_t [DATA_W:0]        dbx_s;
    dbp_block_t               out_r;

    logic vld_r, rdy_r, flush_r, idle_r, pend_r, pflush_r;
    logic vld_nxt_s, rdy_nxt_s, flush_nxt_s, idle_nxt_s, pend_nxt_s, pflush_nxt_s;
    logic out_free_s, word_take_s, pad_take_s, take_s, last_s, complete_s;
    logic load_s, flush_req_s;

    // Word-level datapath decisions for this cycle.
    always_comb begin
        out_free_s  = !vld_r || rdy_i;
        word_take_s = vld_i && rdy_r;
        // A completed block parked in delta_r blocks further padding.
        pad_take_s  = (state_r == ST_PAD) && !pend_r;
        take_s      = word_take_s || pad_take_s;
        if (pad_take_s) begin
            word_s = '0;
        end else begin
            word_s = data_i;
        end
        delta_new_s = delta_fn(word_s, prev_r);
        last_s      = (cnt_r == CNT_W'(BLOCK_SIZE - 1));
        complete_s  = take_s && last_s;
        // Load either the block completing right now or the one that was parked.
        load_s      = out_free_s && (pend_r || complete_s);
        flush_req_s = (state_r == ST_FILL) && (flush_i || pflush_r);
    end

    // Transform input: the completing delta bypasses delta_r so the block loads with no bubble.
    always_comb begin
        tx_delta_s = delta_r;
        if (complete_s) begin
            tx_delta_s[BLOCK_SIZE-2] = delta_new_s;
        end else begin
            tx_delta_s[BLOCK_SIZE-2] = delta_r[BLOCK_SIZE-2];
        end
    end

    dbx_transform u_dbx_transform (
        .delta (tx_delta_s),
        .dbx   (dbx_s)
    );

    // Counter, parked-block flag and output-valid next values.
    always_comb begin
        pend_nxt_s = (pend_r || complete_s) && !out_free_s;
        vld_nxt_s  = load_s || (vld_r && !rdy_i);
        if (take_s) begin
            if (last_s) begin
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Flush FSM next state; a flush that collides with a word handshake is deferred one cycle.
    always_comb begin
        state_nxt_s  = state_r;
        pflush_nxt_s = pflush_r;
        case (state_r)
            ST_FILL: begin
                if (flush_req_s) begin
                    if (word_take_s) begin
                        pflush_nxt_s = 1'b1;
                    end else begin
                        pflush_nxt_s = 1'b0;
                        if (cnt_r != {CNT_W{1'b0}}) begin
                            state_nxt_s = ST_PAD;
                        end else begin
                            state_nxt_s = ST_FLUSH_WAIT;
                        end
                    end
                end else begin
                    pflush_nxt_s = 1'b0;
                end
            end
            ST_PAD: begin
                if (complete_s) begin
                    state_nxt_s = ST_FLUSH_WAIT;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            ST_FLUSH_WAIT: begin
                // Leave as soon as the output register is empty after this edge,
                // so flush_o rises the cycle after the final handshake.
                if (!vld_nxt_s) begin
                    state_nxt_s = ST_FLUSH_HOLD;
                end else begin
                    state_nxt_s = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_HOLD: begin
                if (flush_done_i) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_FLUSH_HOLD;
                end
            end
            default: begin
                state_nxt_s  = ST_FILL;
                pflush_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs derived from next-cycle values.
    always_comb begin
        rdy_nxt_s   = (state_nxt_s == ST_FILL) && !pend_nxt_s && !pflush_nxt_s;
        flush_nxt_s = (state_nxt_s == ST_FLUSH_HOLD);
        idle_nxt_s  = (state_nxt_s == ST_FILL) && (cnt_nxt_s == {CNT_W{1'b0}})
                      && !vld_nxt_s && !pflush_nxt_s;
    end

    // Control and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_FILL;
            cnt_r    <= '0;
            pend_r   <= 1'b0;
            pflush_r <= 1'b0;
            vld_r    <= 1'b0;
            rdy_r    <= 1'b0;
            flush_r  <= 1'b0;
            idle_r   <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            pend_r   <= pend_nxt_s;
            pflush_r <= pflush_nxt_s;
            vld_r    <= vld_nxt_s;
            rdy_r    <= rdy_nxt_s;
            flush_r  <= flush_nxt_s;
            idle_r   <= idle_nxt_s;
        end
    end

    // Accumulation registers: word 0 sets base/prev, later words store deltas.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_r  <= '0;
            prev_r  <= '0;
            delta_r <= '0;
        end else if (take_s) begin
            prev_r <= word_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
                base_r <= word_s;
            end else begin
                base_r <= base_r;
            end
            for (int i = 0; i < BLOCK_SIZE - 1; i++) begin
                if (cnt_r == CNT_W'(i + 1)) begin
                    delta_r[i] <= delta_new_s;
                end else begin
                    delta_r[i] <= delta_r[i];
                end
            end
        end else begin
            prev_r  <= prev_r;
            base_r  <= base_r;
            delta_r <= delta_r;
        end
    end

    // Output block register, reloaded only when empty or draining.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_r <= '0;
        end else if (load_s) begin
            out_r.base <= base_r;
            out_r.dbp  <= dbx_s;
        end else begin
            out_r <= out_r;
        end
    end

    assign dbp_block_o = out_r;
    assign vld_o       = vld_r;
    assign rdy_o       = rdy_r;
    assign flush_o     = flush_r;
    assign idle_o      = idle_r;

endmodule
